// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operand width, M-extension funct3 encodings and sequencer states.
package mdu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3Mul    = 3'b000;
   localparam logic [2:0] F3Mulh   = 3'b001;
   localparam logic [2:0] F3Mulhsu = 3'b010;
   localparam logic [2:0] F3Mulhu  = 3'b011;
   localparam logic [2:0] F3Div    = 3'b100;
   localparam logic [2:0] F3Divu   = 3'b101;
   localparam logic [2:0] F3Rem    = 3'b110;
   localparam logic [2:0] F3Remu   = 3'b111;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } mdu_state_e;

   // Divide-class ops all have funct3[2] set.
   function automatic logic is_div_op(logic [2:0] f3);
      return f3[2];
   endfunction

   // Remainder ops (REM/REMU) have funct3[2:1] = 2'b11.
   function automatic logic is_rem_op(logic [2:0] f3);
      return f3[2] & f3[1];
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath: shift-add for multiply,
// restoring trial-subtract for divide. Purely combinational.
module mdu_step
   import mdu_pkg::*;
(
   input  logic            div_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            ge;

   always_comb begin
      // Multiply: {hi,lo} holds partial product over the remaining multiplier bits.
      sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, a_i} : '0);
      // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
      shifted = {hi_i, lo_i[XLEN-1]};
      ge      = (shifted >= {1'b0, a_i});
      diff    = shifted[XLEN-1:0] - a_i;
      if (div_i) begin
         hi_o = ge ? diff : shifted[XLEN-1:0];
         lo_o = {lo_i[XLEN-2:0], ge};
      end else begin
         hi_o = sum[XLEN:1];
         lo_o = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: 32 iterations per op, with a fast
// path for divide-by-zero and signed overflow. Stalls the core until done.
module mdu_seq #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   import mdu_pkg::*;

   mdu_state_e state_q, state_d;

   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic            negq_q, negq_d;
   logic            negr_q, negr_d;
   logic [4:0]      count_q, count_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            signed_a, signed_b, sign_a, sign_b;
   logic [XLEN-1:0] abs_a, abs_b;
   logic            div_zero, div_ovf, fast;
   logic [XLEN-1:0] fast_res;
   logic            accept, advance, last;
   logic [XLEN-1:0] step_hi, step_lo;
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0] quo_fix, rem_fix, final_res;

   // Operand preparation and fast-path detection on the incoming instruction.
   always_comb begin
      signed_a = (funct3_i == F3Mul) || (funct3_i == F3Mulh) || (funct3_i == F3Mulhsu) ||
                 (funct3_i == F3Div) || (funct3_i == F3Rem);
      signed_b = (funct3_i == F3Mul) || (funct3_i == F3Mulh) ||
                 (funct3_i == F3Div) || (funct3_i == F3Rem);
      sign_a   = signed_a & rs1_i[XLEN-1];
      sign_b   = signed_b & rs2_i[XLEN-1];
      abs_a    = sign_a ? (~rs1_i + 1'b1) : rs1_i;
      abs_b    = sign_b ? (~rs2_i + 1'b1) : rs2_i;
      div_zero = is_div_op(funct3_i) && (rs2_i == '0);
      div_ovf  = ((funct3_i == F3Div) || (funct3_i == F3Rem)) &&
                 (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
      fast     = div_zero | div_ovf;
      if (div_zero) begin
         fast_res = is_rem_op(funct3_i) ? rs1_i : '1;
      end else begin
         fast_res = is_rem_op(funct3_i) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
   end

   assign accept  = (state_q == StIdle) && start_i && !flush_i;
   assign advance = (state_q == StBusy) && start_i && !flush_i;
   assign last    = (count_q == 5'd31);

   mdu_step u_step (
      .div_i (is_div_op(op_q)),
      .a_i   (a_q),
      .hi_i  (hi_q),
      .lo_i  (lo_q),
      .hi_o  (step_hi),
      .lo_o  (step_lo)
   );

   // Sign correction of the final iteration's output.
   always_comb begin
      prod     = {step_hi, step_lo};
      prod_fix = negq_q ? (~prod + 1'b1) : prod;
      quo_fix  = negq_q ? (~step_lo + 1'b1) : step_lo;
      rem_fix  = negr_q ? (~step_hi + 1'b1) : step_hi;
      final_res = '0;
      unique case (op_q)
         F3Mul:                      final_res = prod_fix[XLEN-1:0];
         F3Mulh, F3Mulhsu, F3Mulhu:  final_res = prod_fix[2*XLEN-1:XLEN];
         F3Div, F3Divu:              final_res = quo_fix;
         F3Rem, F3Remu:              final_res = rem_fix;
         default:                    final_res = '0;
      endcase
   end

   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      count_d  = count_q;
      result_d = result_q;
      if (accept) begin
         op_d    = funct3_i;
         a_d     = abs_b;
         hi_d    = '0;
         lo_d    = abs_a;
         negq_d  = sign_a ^ sign_b;
         negr_d  = sign_a;
         count_d = '0;
         if (fast) begin
            result_d = fast_res;
         end
      end else if (advance) begin
         hi_d = step_hi;
         lo_d = step_lo;
         if (last) begin
            result_d = final_res;
         end else begin
            count_d = count_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q     <= '0;
         a_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         count_q  <= '0;
         result_q <= '0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         negq_q   <= negq_d;
         negr_q   <= negr_d;
         count_q  <= count_d;
         result_q <= result_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // A dropped start_i while busy means the instruction was squashed.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_i && !flush_i) begin
               state_d = fast ? StDone : StBusy;
            end
         end
         StBusy: begin
            if (flush_i || !start_i) begin
               state_d = StIdle;
            end else if (last) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      stall_o  = start_i && (state_q != StDone);
      done_o   = (state_q == StDone) && !flush_i;
      result_o = result_q;
   end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM.
- Sits beside the ALU in the single-cycle core.
- Driven by the control unit's Mul_ext_o decode together with the instruction's funct3 and register operands.
- Stalls the PC/register-file write until the result is ready, then presents it for write-back.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  M-extension instruction present; held high by the core while stalled
- funct3_i  in  3  M-op select, sampled at start
- rs1_i  in  XLEN  operand A, sampled at start
- rs2_i  in  XLEN  operand B, sampled at start
- flush_i  in  1  abort the current operation
- stall_o  out  1  freeze PC and suppress RegWEn this cycle
- done_o  out  1  result_o valid; write-back cycle
- result_o  out  XLEN  rd value

Behaviour:
- States are IDLE, BUSY and DONE. On reset (async, any state): IDLE, count=0, done_o=0, result_o=0, internal registers cleared.
- stall_o = start_i & (state != DONE), combinational. It is 0 in IDLE when start_i=0.
- IDLE with start_i=1 and flush_i=0:
  - Latch funct3 and operands.
  - Fast path to DONE when:
    - DIV/DIVU/REM/REMU with rs2=0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result rs1.
    - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV result 0x80000000; REM result 0.
  - Otherwise go to BUSY with count=0.
- Operand preparation:
  - Signed ops take absolute values. MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats rs1 signed, rs2 unsigned. MULHU/DIVU/REMU treat both as unsigned.
  - neg_q = signA^signB (quotient/product sign); neg_r = signA (remainder sign).
- BUSY, one iteration per cycle, exactly 32 cycles (count 0..31):
  - Multiply: 64-bit shift-add on the multiplier LSB.
  - Divide: restoring shift-subtract producing one quotient bit per cycle.
  - At count=31: go to DONE, registering the final sign-corrected result.
  - Multiply result: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32 bits of the sign-corrected 64-bit product (two's-complement negate over all 64 bits).
- DONE, exactly one cycle:
  - done_o=1, result_o valid, stall_o=0.
  - Next state is IDLE. If start_i is still high in the following IDLE cycle, that is a new instruction and starts a new operation (back-to-back allowed).
- Latency: normal op gives 33 stall cycles plus 1 DONE cycle; fast path gives 1 stall cycle plus 1 DONE cycle.
- flush_i=1 in any state: next state IDLE, done_o=0, no result. flush_i wins over start_i in the same cycle.
- start_i deasserted during BUSY is treated as flush: next state IDLE.
- result_o holds its last value in IDLE/BUSY. It is only meaningful when done_o=1.
- count is 5 bits and does not wrap: it is cleared on entering BUSY.

Decomposition:
- Shared package (mdu_pkg):
  - funct3 constants MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - State enum {IDLE, BUSY, DONE}.
  - XLEN.
- One natural sub-module, mdu_step: combinational single-iteration datapath (add-or-pass for multiply, trial-subtract for divide) feeding the sequencer's registers.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> 33 cycles stall_o=1, then done_o=1 for 1 cycle, result_o=0xFFFFFFEB.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast paths, each with 1 stall cycle then done_o:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- flush_i pulsed at BUSY cycle 10 -> IDLE next cycle, done_o never asserted. Then a MUL 3*4 issued in the DONE cycle of a prior op -> back-to-back result 12 after 33 stalls.
- rst_ni dropped mid-BUSY (count=20) -> immediately state IDLE, stall_o=start_i, done_o=0, result_o=0. After release, a fresh DIVU 9/3 -> 3.
